// File: rtl/rs_232_in.sv
// 8N2 asynchronous serial receiver: oversampled start/data/stop recovery
// with a ready/ack output register, framing-error and overrun flags.
module rs_232_in #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       shiftin,
  input  logic       ack,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ready_q, ready_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                busy_q, busy_d;
  logic                commit_c;
  logic                rx;

  assign rx = sync_q[SYNC_STAGES-1];

  // Line synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], shiftin};
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: frame sequencing, sampling at mid-bit
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    commit_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (!rx) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_q == HALF_LAST) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx ? S_IDLE : S_DATA;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_DATA: begin
        if (tick_q == FULL_LAST) begin
          tick_d  = '0;
          shreg_d = {rx, shreg_q[DATA_W-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_STOP: begin
        if (tick_q == FULL_LAST) begin
          tick_d   = '0;
          commit_c = 1'b1;
          state_d  = rx ? S_IDLE : S_BREAK;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_BREAK: begin
        if (rx) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disabling abandons any partial frame, including one at its commit point
    if (!enable) begin
      state_d  = S_IDLE;
      tick_d   = '0;
      bit_d    = '0;
      commit_c = 1'b0;
    end
  end

  // Output register and host handshake
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d != S_IDLE);

    if (commit_c) begin
      data_d  = shreg_q;
      ferr_d  = ~rx;
      ready_d = 1'b1;
      ovr_d   = ack ? 1'b0 : (ovr_q | ready_q);
    end else if (ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign data_out    = data_q;
  assign data_ready  = ready_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rs_232_in.sv
// Bench for rs_232_in: serial frames driven bit by bit, outputs compared
// against a transaction-level model of the receiver's host-visible state.
module tb_rs_232_in;

  localparam int unsigned OS = 16;

  localparam int ACT_NONE   = 0;
  localparam int ACT_RESET  = 1;
  localparam int ACT_ENABLE = 2;
  localparam int ACT_ACK    = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       shiftin;
  logic       ack;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  rs_232_in #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .shiftin     (shiftin),
    .ack         (ack),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Records the cycle at which data_ready last went high
  int unsigned rise_cyc = 0;
  logic        dr_q = 1'b0;
  always @(negedge clock) begin
    if (data_ready && !dr_q) rise_cyc = cyc;
    dr_q = data_ready;
  end

  logic [7:0] m_data;
  logic       m_ready, m_ferr, m_ovr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_data"},  32'(data_out),    32'(m_data));
    chk({tag, "_ready"}, 32'(data_ready),  32'(m_ready));
    chk({tag, "_ferr"},  32'(frame_error), 32'(m_ferr));
    chk({tag, "_ovr"},   32'(overrun),     32'(m_ovr));
  endtask

  task automatic idle_bits(input int n);
    shiftin = 1'b1;
    repeat (n * OS) @(posedge clock);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clock);
    #1;
    ack = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Disturbance applied at tick h of the frame bit selected by the caller
  task automatic do_action(input int kind, input int h);
    case (kind)
      ACT_RESET: begin
        if (h == 8) begin
          chk("pre_rst_busy", 32'(busy), 32'd1);
          #2 reset = 1'b1;
          #1;
          chk("rst_async_data",  32'(data_out),    32'd0);
          chk("rst_async_ready", 32'(data_ready),  32'd0);
          chk("rst_async_ferr",  32'(frame_error), 32'd0);
          chk("rst_async_ovr",   32'(overrun),     32'd0);
          chk("rst_async_busy",  32'(busy),        32'd0);
          m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        end
        if (h == 10) reset = 1'b0;
      end
      ACT_ENABLE: begin
        if (h == 8) enable = 1'b0;
        if (h == 9) enable = 1'b1;
      end
      ACT_ACK: begin
        if (h == 10) ack = 1'b1;
        if (h == 11) ack = 1'b0;
      end
      default: ;
    endcase
  endtask

  // Drives one frame; stop_low > 0 holds the line low for that many bit times
  // from the first stop bit and returns with the line still low.
  task automatic send(input logic [7:0] b, input int stop_low, input int act_bit,
                      input int kind, output int unsigned first_low);
    int nbits;
    nbits = (stop_low > 0) ? 9 + stop_low : 11;
    first_low = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)      shiftin = 1'b0;
      else if (i <= 8) shiftin = b[i-1];
      else             shiftin = (stop_low > 0) ? 1'b0 : 1'b1;
      for (int h = 0; h < OS; h++) begin
        if (i == act_bit) do_action(kind, h);
        @(posedge clock);
        #1;
      end
    end
    if (kind == ACT_NONE || kind == ACT_ACK) begin
      m_ovr   = (kind == ACT_ACK) ? 1'b0 : (m_ovr | m_ready);
      m_data  = b;
      m_ready = 1'b1;
      m_ferr  = (stop_low > 0);
    end
  endtask

  initial begin
    int unsigned fl;
    logic [7:0]  rb;
    int          sl;

    reset = 1'b1; enable = 1'b1; shiftin = 1'b1; ack = 1'b0;
    m_data = 8'h00; m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_outputs("reset");
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle_bits(2);

    // Single frame, latency and handshake
    send(8'hA5, 0, -1, ACT_NONE, fl);
    chk("latency_154pm1", 32'((rise_cyc - fl) >= 153 && (rise_cyc - fl) <= 155), 32'd1);
    check_outputs("a5");
    chk("a5_busy_idle", 32'(busy), 32'd0);
    pulse_ack();
    check_outputs("a5_ack");

    // Start-bit glitch shorter than half a bit
    shiftin = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    shiftin = 1'b1;
    idle_bits(2);
    chk("glitch_busy", 32'(busy), 32'd0);
    check_outputs("glitch");

    // Back-to-back frames without and with ack on the commit cycle
    send(8'h3C, 0, -1, ACT_NONE, fl);
    send(8'hFF, 0, -1, ACT_NONE, fl);
    check_outputs("b2b_overrun");
    pulse_ack();
    check_outputs("b2b_ack");
    send(8'h3C, 0, -1, ACT_NONE, fl);
    send(8'hFF, 0, 9, ACT_ACK, fl);
    check_outputs("b2b_ack_at_commit");
    pulse_ack();

    // Framing error followed by a long break
    send(8'h81, 40, -1, ACT_NONE, fl);
    check_outputs("break");
    chk("break_busy", 32'(busy), 32'd1);
    pulse_ack();
    shiftin = 1'b0;
    repeat (5 * OS) @(posedge clock);
    #1;
    chk("break_busy_late", 32'(busy), 32'd1);
    check_outputs("break_single_commit");
    idle_bits(2);
    chk("break_end_busy", 32'(busy), 32'd0);
    send(8'h55, 0, -1, ACT_NONE, fl);
    check_outputs("after_break");

    // Asynchronous reset during data bit 4
    rb = {4'hF, 4'($urandom_range(0, 15))};
    send(rb, 0, 5, ACT_RESET, fl);
    check_outputs("post_reset");
    chk("post_reset_busy", 32'(busy), 32'd0);
    idle_bits(1);
    send(8'h0F, 0, -1, ACT_NONE, fl);
    check_outputs("frame_0f");

    // One-cycle enable drop mid-frame
    rb = {4'hF, 4'($urandom_range(0, 15))};
    send(rb, 0, 5, ACT_ENABLE, fl);
    check_outputs("enable_drop");
    chk("enable_drop_busy", 32'(busy), 32'd0);
    idle_bits(20);
    send(8'hC3, 0, -1, ACT_NONE, fl);
    check_outputs("frame_c3");

    // Random frames, gaps, acks and occasional bad stop bits
    for (int k = 0; k < 12; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle_bits(gap);
      if ($urandom_range(0, 1) == 1) pulse_ack();
      rb = 8'($urandom_range(0, 255));
      sl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      send(rb, sl, -1, ACT_NONE, fl);
      check_outputs("rand");
      if (sl > 0) idle_bits(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_232_in.md
Name: rs_232_in

Overview:
- 8-bit asynchronous serial receiver. It is the receiving end of the team's 8N2 RS-232 link: 1 low start bit, 8 data bits LSB first, no parity, 2 high stop bits, 9600 bit/s.
- It oversamples the line, recovers each byte, and holds it in an output register with a ready/ack handshake to the host logic.
- It also reports framing errors and overruns.

Parameters:
- OVERSAMPLE, 16: clock cycles per bit period. Must be even and ≥ 4. Default implies clock = 153.6 kHz for 9600 bit/s.
- SYNC_STAGES, 2: number of flip-flops in the `shiftin` synchronizer, ≥ 2.

Ports:
- clock  input  1  receiver clock, OVERSAMPLE × bit rate
- reset  input  1  asynchronous, active-high reset
- enable  input  1  receiver enable; low forces the FSM to IDLE
- shiftin  input  1  asynchronous serial line, idles high
- ack  input  1  host has consumed `data_out`; clears `data_ready` and `overrun`
- data_out  output  8  last received byte
- data_ready  output  1  `data_out` holds an unread byte
- frame_error  output  1  stop bit of the byte in `data_out` was sampled low
- overrun  output  1  a byte was overwritten before `ack`
- busy  output  1  FSM not in IDLE

Behaviour:

Reset (asynchronous, any time including mid-frame):
- FSM goes to IDLE.
- `data_out` = 8'h00; `data_ready`, `frame_error`, `overrun`, `busy` = 0.
- Synchronizer flops = 1; bit counter and tick counter = 0.

Synchronizer:
- `shiftin` passes through SYNC_STAGES flops. All FSM decisions use the synchronized value `rx`.

FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `rx` = 0 with `enable` = 1 → START, tick counter = 0.
- START: count OVERSAMPLE/2 ticks to mid start bit, then sample `rx`.
  - `rx` = 1: false start, go to IDLE.
  - `rx` = 0: tick counter = 0, bit counter = 0, go to DATA.
- DATA: every OVERSAMPLE ticks (mid-bit), shift `rx` into the shift register, LSB first.
  - After bit counter reaches 7 and that bit is sampled → STOP, tick counter = 0.
- STOP: after OVERSAMPLE ticks, sample `rx` (first stop bit) and commit (see below).
  - `rx` = 1 → IDLE.
  - `rx` = 0 → BREAK.
  - Only the first stop bit is checked. The second stop bit is treated as idle line, which gives one bit time of resynchronisation margin.
- BREAK: wait until `rx` = 1, then go to IDLE. No further bytes are committed while the line stays low.
- `enable` = 0 in any state: next cycle the FSM is in IDLE and the partial byte is discarded. `data_out`, `data_ready`, `frame_error` and `overrun` are retained.

Commit (single cycle, at the stop-bit sample):
- `data_out` ← shift register; `frame_error` ← ~`rx`; `data_ready` ← 1.
- If `data_ready` was already 1 and `ack` is not asserted this cycle, `overrun` ← 1. `data_out` is still overwritten; the newest byte wins.
- `ack` in the same cycle as a commit: the new byte is presented, `data_ready` stays 1, `overrun` is not set.

Handshake:
- `ack` with no commit in the same cycle clears `data_ready` and `overrun` on the next edge.
- `data_out` and `frame_error` hold their values until the next commit.
- `ack` while `data_ready` = 0 has no effect.

Latency and width rules:
- `data_ready` rises SYNC_STAGES + OVERSAMPLE/2 + 9·OVERSAMPLE clock edges after the first edge at which `shiftin` is low. With defaults this is 154, with ±1 edge for synchronizer phase.
- Tick counter width is clog2(OVERSAMPLE). Bit counter is 3 bits. No wrap-around is visible outside the FSM.
- `busy` = 1 in START, DATA, STOP and BREAK.

Test Plan:
1. Reset, `enable` = 1, send frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1,1 at 16 clocks/bit) → `data_out` = 8'hA5, `data_ready` = 1 at edge 154±1, `frame_error` = 0, `overrun` = 0; then `ack` → `data_ready` = 0 next cycle.
2. Glitch: `shiftin` low for 5 clocks, then high → FSM returns to IDLE, no commit, `data_ready` stays 0.
3. Two back-to-back frames 0x3C then 0xFF with no `ack` → `data_out` = 8'hFF, `overrun` = 1. Repeat with `ack` pulsed on the exact second-commit cycle → `overrun` = 0, `data_ready` = 1.
4. Frame 0x81 with first stop bit forced low, line held low for 40 bit times → `data_out` = 8'h81, `frame_error` = 1. Exactly one commit occurs; `busy` stays 1 until the line returns high. The next valid frame 0x55 → `frame_error` = 0.
5. Assert `reset` at DATA bit 4 of a frame → all outputs 0 immediately (asynchronously). After release, the rest of the frame is not committed and the following frame 0x0F is received correctly.
6. Drop `enable` for 1 clock mid-frame → no commit for that frame, previous `data_out` retained. A frame 0xC3 sent 20 bit times later is received correctly.
